dmem_port: RTL and testbench

- Memory-stage bridge downstream of the single-cycle data path.
- Consumes the data path's ALU result (address), register write data and the controller's mem_read/mem_write.
- Drives a variable-latency req/ack data-memory bus and returns read data to the data path's read-data input.
- Raises a stall so the PC register and register file hold until the access completes. Also flags misaligned accesses and bus timeouts.

---
 rtl/dmem_port.sv | 177 +++++++++++++++++
 tb/tb_dmem_port.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port.sv
// ----------------------------------------------------------------------------
// dmem_port
//
// Memory-stage bridge between a single-cycle data path and a variable-latency
// req/ack data-memory bus. A load or store presented by the controller is
// latched, issued on the bus from a registered BUSY state, and completed in a
// DONE cycle where the data path commits. While the access is in flight the
// stall output freezes the PC and register-file write.
//
// Ports:
//   clk_i          clock, rising edge
//   reset_i        synchronous active-high reset
//   mem_read_i     load request (level, held while stalled)
//   mem_write_i    store request (level, held while stalled); wins over read
//   addr_i32       byte address from the ALU
//   wdata_i32      store data
//   rdata_o32      load data returned to the data path
//   stall_o        hold PC / register file while high
//   misalign_o     one-cycle flag: misaligned access rejected
//   timeout_o      sticky: an access exceeded TIMEOUT_CYCLES BUSY cycles
//   bus_req_o      bus request, high for every BUSY cycle
//   bus_we_o       bus write enable, valid with bus_req_o
//   bus_addr_o32   latched word address ([1:0] forced to 0)
//   bus_wdata_o32  latched store data
//   bus_ack_i      one-cycle completion strobe
//   bus_rdata_i32  read data, valid with bus_ack_i
//
// Parameters:
//   TIMEOUT_CYCLES BUSY cycles without ack before abort (2..255)
// ----------------------------------------------------------------------------
module dmem_port #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [31:0] addr_i32,
   input  logic [31:0] wdata_i32,
   output logic [31:0] rdata_o32,
   output logic        stall_o,
   output logic        misalign_o,
   output logic        timeout_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o32,
   output logic [31:0] bus_wdata_o32,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i32
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter value seen in the last permitted BUSY cycle without ack.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [31:0] rdata_q, rdata_d;
   logic        timeout_q, timeout_d;

   logic        access;
   logic        aligned;
   logic        stall;
   logic        misalign;

   assign access  = mem_read_i | mem_write_i;
   assign aligned = (addr_i32[1:0] == 2'b00);

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      rdata_d   = rdata_q;
      timeout_d = timeout_q;
      stall     = 1'b0;
      misalign  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (access) begin
               if (aligned) begin
                  addr_d  = {addr_i32[31:2], 2'b00};
                  wdata_d = wdata_i32;
                  we_d    = mem_write_i;
                  cnt_d   = '0;
                  state_d = BUSY;
                  stall   = 1'b1;
               end else begin
                  // Rejected: no bus activity, the load sees zero this cycle.
                  misalign = 1'b1;
               end
            end
         end

         BUSY: begin
            stall = 1'b1;
            // Ack is checked first so it wins over a same-cycle timeout.
            if (bus_ack_i) begin
               if (!we_q) begin
                  rdata_d = bus_rdata_i32;
               end
               state_d = DONE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               timeout_d = 1'b1;
               if (!we_q) begin
                  rdata_d = '0;
               end
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         DONE: begin
            // Request levels are deliberately not sampled here so the same
            // instruction's access is never issued twice.
            cnt_d   = '0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         rdata_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         rdata_q   <= rdata_d;
         timeout_q <= timeout_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // Request is derived from the registered state only, never from the
   // incoming request level.
   assign bus_req_o     = (state_q == BUSY);
   assign bus_we_o      = we_q;
   assign bus_addr_o32  = addr_q;
   assign bus_wdata_o32 = wdata_q;
   assign timeout_o     = timeout_q;
   assign stall_o       = stall;
   assign misalign_o    = misalign;
   assign rdata_o32     = misalign ? '0 : rdata_q;

endmodule

// File: tb/tb_dmem_port.sv
module tb_dmem_port;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        mem_read_i;
   logic        mem_write_i;
   logic [31:0] addr_i32;
   logic [31:0] wdata_i32;
   logic [31:0] rdata_o32;
   logic        stall_o;
   logic        misalign_o;
   logic        timeout_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o32;
   logic [31:0] bus_wdata_o32;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i32;

   int unsigned total = 0;
   int unsigned bad   = 0;

   dmem_port #(.TIMEOUT_CYCLES(16)) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .mem_read_i    (mem_read_i),
      .mem_write_i   (mem_write_i),
      .addr_i32      (addr_i32),
      .wdata_i32     (wdata_i32),
      .rdata_o32     (rdata_o32),
      .stall_o       (stall_o),
      .misalign_o    (misalign_o),
      .timeout_o     (timeout_o),
      .bus_req_o     (bus_req_o),
      .bus_we_o      (bus_we_o),
      .bus_addr_o32  (bus_addr_o32),
      .bus_wdata_o32 (bus_wdata_o32),
      .bus_ack_i     (bus_ack_i),
      .bus_rdata_i32 (bus_rdata_i32)
   );

   always #5 clk_i = ~clk_i;

   // Each cycle: inputs are driven 1 time unit after the rising edge and
   // outputs are sampled 1 time unit later, well away from either edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_i       = 1'b1;
      mem_read_i    = 1'b0;
      mem_write_i   = 1'b0;
      addr_i32      = '0;
      wdata_i32     = '0;
      bus_ack_i     = 1'b0;
      bus_rdata_i32 = '0;
      tick();
      tick();
      settle();
      chk("rst_stall",   {31'd0, stall_o},    32'd0);
      chk("rst_req",     {31'd0, bus_req_o},  32'd0);
      chk("rst_we",      {31'd0, bus_we_o},   32'd0);
      chk("rst_timeout", {31'd0, timeout_o},  32'd0);
      chk("rst_mis",     {31'd0, misalign_o}, 32'd0);
      chk("rst_rdata",   rdata_o32,           32'd0);
      chk("rst_addr",    bus_addr_o32,        32'd0);
      chk("rst_wdata",   bus_wdata_o32,       32'd0);
      reset_i = 1'b0;
      tick();

      // ---- Load, ack in first BUSY cycle --------------------------------
      mem_read_i = 1'b1;
      addr_i32   = 32'h0000_0010;
      settle();
      chk("ld_idle_stall", {31'd0, stall_o},   32'd1);
      chk("ld_idle_req",   {31'd0, bus_req_o}, 32'd0);
      tick();
      bus_ack_i     = 1'b1;
      bus_rdata_i32 = 32'hCAFE_F00D;
      settle();
      chk("ld_busy_req",   {31'd0, bus_req_o}, 32'd1);
      chk("ld_busy_stall", {31'd0, stall_o},   32'd1);
      chk("ld_busy_addr",  bus_addr_o32,       32'h0000_0010);
      chk("ld_busy_we",    {31'd0, bus_we_o},  32'd0);
      tick();
      bus_ack_i     = 1'b0;
      bus_rdata_i32 = 32'h0;
      settle();
      chk("ld_done_stall", {31'd0, stall_o},   32'd0);
      chk("ld_done_req",   {31'd0, bus_req_o}, 32'd0);
      chk("ld_done_rdata", rdata_o32,          32'hCAFE_F00D);
      mem_read_i = 1'b0;
      tick();
      settle();
      chk("ld_after_stall", {31'd0, stall_o},  32'd0);

      // ---- Store, ack in 4th BUSY cycle ---------------------------------
      mem_write_i = 1'b1;
      addr_i32    = 32'h0000_0020;
      wdata_i32   = 32'h1234_5678;
      settle();
      chk("st_idle_stall", {31'd0, stall_o},   32'd1);
      chk("st_idle_req",   {31'd0, bus_req_o}, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         bus_ack_i = (i == 4);
         settle();
         chk($sformatf("st_busy%0d_req", i),   {31'd0, bus_req_o}, 32'd1);
         chk($sformatf("st_busy%0d_we", i),    {31'd0, bus_we_o},  32'd1);
         chk($sformatf("st_busy%0d_stall", i), {31'd0, stall_o},   32'd1);
         chk($sformatf("st_busy%0d_wdata", i), bus_wdata_o32,      32'h1234_5678);
         chk($sformatf("st_busy%0d_addr", i),  bus_addr_o32,       32'h0000_0020);
      end
      tick();
      bus_ack_i = 1'b0;
      settle();
      chk("st_done_stall", {31'd0, stall_o},   32'd0);
      chk("st_done_req",   {31'd0, bus_req_o}, 32'd0);
      chk("st_done_rdata", rdata_o32,          32'hCAFE_F00D);
      mem_write_i = 1'b0;
      tick();

      // ---- Misaligned load ----------------------------------------------
      mem_read_i = 1'b1;
      addr_i32   = 32'h0000_0013;
      settle();
      chk("mis_flag",  {31'd0, misalign_o}, 32'd1);
      chk("mis_stall", {31'd0, stall_o},    32'd0);
      chk("mis_rdata", rdata_o32,           32'd0);
      chk("mis_req",   {31'd0, bus_req_o},  32'd0);
      tick();
      mem_read_i = 1'b0;
      settle();
      chk("mis_next_req",   {31'd0, bus_req_o},  32'd0);
      chk("mis_next_flag",  {31'd0, misalign_o}, 32'd0);
      chk("mis_next_rdata", rdata_o32,           32'hCAFE_F00D);
      chk("mis_next_addr",  bus_addr_o32,        32'h0000_0020);

      // ---- Misaligned store is dropped ----------------------------------
      mem_write_i = 1'b1;
      addr_i32    = 32'h0000_0031;
      wdata_i32   = 32'hBAD0_BAD0;
      settle();
      chk("mis_st_flag", {31'd0, misalign_o}, 32'd1);
      tick();
      mem_write_i = 1'b0;
      settle();
      chk("mis_st_req",   {31'd0, bus_req_o}, 32'd0);
      chk("mis_st_wdata", bus_wdata_o32,      32'h1234_5678);

      // ---- Timeout: load, no ack ----------------------------------------
      mem_read_i = 1'b1;
      addr_i32   = 32'h0000_0040;
      settle();
      chk("to_idle_stall", {31'd0, stall_o}, 32'd1);
      for (int i = 1; i <= 16; i++) begin
         tick();
         settle();
         chk($sformatf("to_busy%0d_req", i), {31'd0, bus_req_o}, 32'd1);
         chk($sformatf("to_busy%0d_to", i),  {31'd0, timeout_o}, 32'd0);
      end
      tick();
      settle();
      chk("to_done_req",   {31'd0, bus_req_o}, 32'd0);
      chk("to_done_stall", {31'd0, stall_o},   32'd0);
      chk("to_done_flag",  {31'd0, timeout_o}, 32'd1);
      chk("to_done_rdata", rdata_o32,          32'd0);
      mem_read_i = 1'b0;
      tick();
      settle();
      chk("to_sticky", {31'd0, timeout_o}, 32'd1);
      // Following access completes normally.
      mem_read_i = 1'b1;
      addr_i32   = 32'h0000_0044;
      tick();
      bus_ack_i     = 1'b1;
      bus_rdata_i32 = 32'hA5A5_0001;
      settle();
      chk("to_next_req",  {31'd0, bus_req_o}, 32'd1);
      chk("to_next_addr", bus_addr_o32,       32'h0000_0044);
      tick();
      bus_ack_i = 1'b0;
      settle();
      chk("to_next_rdata",  rdata_o32,          32'hA5A5_0001);
      chk("to_next_sticky", {31'd0, timeout_o}, 32'd1);
      mem_read_i = 1'b0;
      tick();

      // ---- Reset mid-access ---------------------------------------------
      mem_read_i = 1'b1;
      addr_i32   = 32'h0000_0050;
      tick();
      tick();
      settle();
      chk("rm_busy2_req", {31'd0, bus_req_o}, 32'd1);
      reset_i    = 1'b1;
      mem_read_i = 1'b0;
      tick();
      reset_i       = 1'b0;
      bus_ack_i     = 1'b1;
      bus_rdata_i32 = 32'hDEAD_BEEF;
      settle();
      chk("rm_req",     {31'd0, bus_req_o}, 32'd0);
      chk("rm_stall",   {31'd0, stall_o},   32'd0);
      chk("rm_rdata",   rdata_o32,          32'd0);
      chk("rm_timeout", {31'd0, timeout_o}, 32'd0);
      tick();
      bus_ack_i = 1'b0;
      settle();
      chk("rm_late_rdata", rdata_o32,          32'd0);
      chk("rm_late_req",   {31'd0, bus_req_o}, 32'd0);

      // ---- Stray ack, then back-to-back load/store ----------------------
      bus_ack_i     = 1'b1;
      bus_rdata_i32 = 32'hFFFF_FFFF;
      settle();
      chk("stray_stall", {31'd0, stall_o},   32'd0);
      tick();
      bus_ack_i = 1'b0;
      settle();
      chk("stray_rdata", rdata_o32,          32'd0);
      chk("stray_req",   {31'd0, bus_req_o}, 32'd0);
      mem_read_i = 1'b1;
      addr_i32   = 32'h0000_0060;
      tick();
      bus_ack_i     = 1'b1;
      bus_rdata_i32 = 32'h1111_2222;
      settle();
      chk("b2b_ld_req", {31'd0, bus_req_o}, 32'd1);
      tick();
      bus_ack_i = 1'b0;
      settle();
      chk("b2b_ld_rdata", rdata_o32,        32'h1111_2222);
      chk("b2b_ld_stall", {31'd0, stall_o}, 32'd0);
      tick();
      mem_read_i  = 1'b1;
      mem_write_i = 1'b1;
      addr_i32    = 32'h0000_0064;
      wdata_i32   = 32'h3333_4444;
      settle();
      chk("b2b_st_accept", {31'd0, stall_o}, 32'd1);
      tick();
      bus_ack_i = 1'b1;
      settle();
      chk("b2b_st_req",   {31'd0, bus_req_o}, 32'd1);
      chk("b2b_st_we",    {31'd0, bus_we_o},  32'd1);
      chk("b2b_st_addr",  bus_addr_o32,       32'h0000_0064);
      chk("b2b_st_wdata", bus_wdata_o32,      32'h3333_4444);
      tick();
      bus_ack_i = 1'b0;
      settle();
      chk("b2b_st_done_rdata", rdata_o32,        32'h1111_2222);
      chk("b2b_st_done_stall", {31'd0, stall_o}, 32'd0);
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
